// File: rtl/divisor_8bits_pkg.sv
// divisor_8bits shared definitions.
// State encoding, iteration count and div-by-zero quotient.
package divisor_8bits_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         ITER    = 8;
  localparam logic [2:0] LAST_IT = 3'(ITER - 1);
  localparam logic [7:0] DIVZ_Q  = 8'hFF;

endpackage

// File: rtl/divisor_8bits_subtrator.sv
// Ripple subtractor built from full-adder cells.
// S = A + ~B + 1; B_out is high when A < B.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module subtrator_8bits (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] S,
  output logic       B_out
);

  logic [8:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    full_adder u_fa (
      .a  (A[i]),
      .b  (~B[i]),
      .ci (c[i]),
      .s  (S[i]),
      .co (c[i+1])
    );
  end

  assign B_out = ~c[8];

endmodule

// File: rtl/divisor_8bits.sv
// 8-bit restoring divider, one quotient bit per clock.
// start/busy/done handshake, results held until next completion.
module divisor_8bits
  import divisor_8bits_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] Q,
  output logic [7:0] R,
  output logic       busy,
  output logic       done,
  output logic       div_zero
);

  state_t     state, nxt;
  logic [7:0] a_sh;
  logic [7:0] b_reg;
  logic [7:0] p;
  logic [7:0] q_acc;
  logic [2:0] cnt;
  logic [8:0] t;
  logic [7:0] diff;
  logic       brw;
  logic       take;
  logic       accept;

  // P stays below B, so it never needs its ninth bit between steps
  assign t = {p, a_sh[7]};

  subtrator_8bits u_sub (
    .A     (t[7:0]),
    .B     (b_reg),
    .S     (diff),
    .B_out (brw)
  );

  assign take   = t[8] | ~brw;
  assign accept = start & ((state == IDLE) | (state == DONE));
  assign busy   = (state == CALC);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) nxt = (B == 8'd0) ? DONE : CALC;
      end
      CALC: begin
        if (cnt == LAST_IT) nxt = DONE;
      end
      DONE: begin
        if (start) nxt = (B == 8'd0) ? DONE : CALC;
        else       nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_reg    <= '0;
      p        <= '0;
      q_acc    <= '0;
      cnt      <= '0;
      Q        <= '0;
      R        <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      a_sh  <= A;
      b_reg <= B;
      p     <= '0;
      q_acc <= '0;
      cnt   <= '0;
      if (B == 8'd0) begin
        Q        <= DIVZ_Q;
        R        <= A;
        div_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      a_sh  <= {a_sh[6:0], 1'b0};
      p     <= take ? diff : t[7:0];
      q_acc <= {q_acc[6:0], take};
      cnt   <= cnt + 3'd1;
      if (cnt == LAST_IT) begin
        Q        <= {q_acc[6:0], take};
        R        <= take ? diff : t[7:0];
        div_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divisor_8bits.sv
// Directed and random checks of divisor_8bits
// against a plain-arithmetic reference.
module tb_divisor_8bits;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] q;
  logic [7:0] r;
  logic       busy;
  logic       done;
  logic       div_zero;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  divisor_8bits dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (a),
    .B        (b),
    .Q        (q),
    .R        (r),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full operation, checked for latency, busy length and results
  task automatic run_op(input logic [7:0] a_i, input logic [7:0] b_i,
                        input string tag);
    int         n;
    int         nbusy;
    int         ovl;
    bit         seen;
    logic [7:0] eq;
    logic [7:0] er;
    eq = (b_i == 0) ? 8'hFF : a_i / b_i;
    er = (b_i == 0) ? a_i : a_i % b_i;
    @(negedge clk);
    a = a_i;
    b = b_i;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    n = 0;
    nbusy = 0;
    ovl = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
      if (busy && done) ovl++;
      if (done) seen = 1;
    end
    chk({tag, "_lat"}, n, (b_i == 0) ? 1 : 9);
    chk({tag, "_busy"}, nbusy, (b_i == 0) ? 0 : 8);
    chk({tag, "_ovl"}, ovl, 0);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    chk({tag, "_dz"}, div_zero, (b_i == 0) ? 1 : 0);
    @(negedge clk);
    chk({tag, "_dfall"}, done, 0);
    chk({tag, "_qhold"}, q, eq);
  endtask

  initial begin
    int         nd;
    int         pos[$];
    logic [7:0] qs[$];
    logic [7:0] rs[$];
    logic [7:0] ra;
    logic [7:0] rb;

    #12;
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd200, 8'd7, "d200_7");
    run_op(8'd255, 8'd1, "d255_1");
    run_op(8'd5, 8'd9, "d5_9");
    run_op(8'd0, 8'd3, "d0_3");
    run_op(8'd77, 8'd0, "dz77");
    run_op(8'd77, 8'd7, "d77_7");

    // start during CALC must be ignored
    @(negedge clk);
    a = 8'd100;
    b = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) begin
        start = 1'b1;
        a = 8'd9;
        b = 8'd9;
      end
      if (i == 6) begin
        start = 1'b0;
        a = 8'd1;
        b = 8'd1;
      end
      if (done) begin
        nd++;
        qs.push_back(q);
        rs.push_back(r);
      end
    end
    chk("ign_ndone", nd, 1);
    if (nd == 1) begin
      chk("ign_q", qs[0], 33);
      chk("ign_r", rs[0], 1);
    end
    qs.delete();
    rs.delete();

    // back-to-back with start held high
    @(negedge clk);
    a = 8'd250;
    b = 8'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'd17;
    b = 8'd4;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 10) start = 1'b0;
      if (done) begin
        pos.push_back(i);
        qs.push_back(q);
        rs.push_back(r);
      end
    end
    chk("b2b_ndone", pos.size(), 2);
    if (pos.size() == 2) begin
      chk("b2b_pos0", pos[0], 9);
      chk("b2b_gap", pos[1] - pos[0], 9);
      chk("b2b_q0", qs[0], 25);
      chk("b2b_r0", rs[0], 0);
      chk("b2b_q1", qs[1], 4);
      chk("b2b_r1", rs[1], 1);
    end

    // asynchronous reset in the 4th CALC cycle
    @(negedge clk);
    a = 8'd200;
    b = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q", q, 0);
    chk("arst_r", r, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_dz", div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("arst_nodone", nd, 0);
    run_op(8'd50, 8'd6, "d50_6");

    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      run_op(ra, rb, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
